// File: rtl/mux_scan_pkg.sv
// Shared definitions for the mux scan sequencer: channel count, select width,
// scan FSM states and the enabled-channel search helper.
// No ports (package only).
`timescale 1ns/1ps
package mux_scan_pkg;

  localparam int MUX_NCH   = 8;
  localparam int MUX_SEL_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    DWELL,
    HOLD
  } scan_state_t;

  // Lowest enabled channel index >= from. Returns MUX_NCH (top bit set)
  // when no enabled channel remains, which callers use as "scan done".
  function automatic logic [MUX_SEL_W:0] next_enabled(
    input logic [MUX_NCH-1:0] mask,
    input logic [MUX_SEL_W:0] from
  );
    logic [MUX_SEL_W:0] res;
    res = (MUX_SEL_W+1)'(MUX_NCH);
    for (int i = MUX_NCH - 1; i >= 0; i--) begin
      if (mask[i] && ((MUX_SEL_W+1)'(i) >= from)) begin
        res = (MUX_SEL_W+1)'(i);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/scan_settle_timer.sv
// Purpose: loadable down-counter with zero flag, paces the per-channel settle.
// Latency: load takes effect on the next edge; zero is combinational from count.
// Backpressure: none; counts down whenever non-zero and not being loaded.
// Ports: clk, rst (sync, active-high), load, load_val[W-1:0] in; zero out.
`timescale 1ns/1ps
module scan_settle_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mux_scan_sequencer.sv
// Purpose: steps the 8:1 mux select through channels, samples each after a
//   settle time and presents the 8-bit snapshot on a valid/ready handshake.
// Latency: start to snap_valid = N*(SETTLE+1) cycles (N visited channels).
// Backpressure: snapshot held stable in HOLD until snap_ready; start ignored
//   while busy.
// Ports: clk, rst (sync, active-high), start, mux_out, snap_ready in;
//   ch_mask[7:0] in (only with MUX_SCAN_MASK_EN); sel[2:0], snap_data[7:0],
//   snap_valid, busy out.
// Optional feature macro: MUX_SCAN_MASK_EN (per-channel enable mask).
`timescale 1ns/1ps
module mux_scan_sequencer
  import mux_scan_pkg::*;
#(
  parameter int SETTLE     = 1,
  parameter bit CONTINUOUS = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
`ifdef MUX_SCAN_MASK_EN
  input  logic [MUX_NCH-1:0]   ch_mask,
`endif
  input  logic                 mux_out,
  output logic [MUX_SEL_W-1:0] sel,
  output logic [MUX_NCH-1:0]   snap_data,
  output logic                 snap_valid,
  input  logic                 snap_ready,
  output logic                 busy
);

  localparam int CW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
  localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE);

  scan_state_t          state, state_nxt;
  logic [MUX_SEL_W-1:0] sel_nxt;
  logic [MUX_NCH-1:0]   data_nxt;
  logic [MUX_NCH-1:0]   mask_q, mask_nxt;
  logic [MUX_NCH-1:0]   mask_in;
  logic [MUX_SEL_W:0]   first_ch, next_ch;
  logic                 tmr_load, tmr_zero, do_start;

`ifdef MUX_SCAN_MASK_EN
  assign mask_in = ch_mask;
`else
  assign mask_in = '1;
`endif

  // The mask is captured at scan start so mid-scan changes cannot alter
  // the walk in progress; next_ch searches the captured copy.
  assign first_ch = next_enabled(mask_in, '0);
  assign next_ch  = next_enabled(mask_q, (MUX_SEL_W+1)'(sel) + (MUX_SEL_W+1)'(1));

  scan_settle_timer #(.W(CW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (SETTLE_LD),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sel       <= '0;
      snap_data <= '0;
      mask_q    <= '0;
    end else begin
      state     <= state_nxt;
      sel       <= sel_nxt;
      snap_data <= data_nxt;
      mask_q    <= mask_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    sel_nxt    = sel;
    data_nxt   = snap_data;
    mask_nxt   = mask_q;
    tmr_load   = 1'b0;
    do_start   = 1'b0;
    snap_valid = (state == HOLD);
    busy       = (state != IDLE);

    unique case (state)
      IDLE: begin
        do_start = start;
      end
      DWELL: begin
        if (tmr_zero) begin
          data_nxt[sel] = mux_out;
          if (next_ch[MUX_SEL_W]) begin
            state_nxt = HOLD;
          end else begin
            sel_nxt  = next_ch[MUX_SEL_W-1:0];
            tmr_load = 1'b1;
          end
        end
      end
      HOLD: begin
        if (snap_ready) begin
          if (CONTINUOUS) begin
            do_start = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Shared by the IDLE start and the back-to-back continuous restart so
    // the next scan begins on the handshake edge with no dead cycle.
    if (do_start) begin
      mask_nxt = mask_in;
      data_nxt = '0;
      if (first_ch[MUX_SEL_W]) begin
        // Nothing enabled: present an all-zero snapshot straight away.
        state_nxt = HOLD;
        sel_nxt   = '0;
      end else begin
        state_nxt = DWELL;
        sel_nxt   = first_ch[MUX_SEL_W-1:0];
        tmr_load  = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
`timescale 1ns/1ps
module tb_mux_scan_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] mask_all = 8'hFF;

  // single-scan instance
  logic       start_a, ready_a, valid_a, busy_a, mux_a;
  logic [2:0] sel_a;
  logic [7:0] in_a, data_a;
  assign mux_a = in_a[sel_a];

  // continuous instance
  logic       start_c, ready_c, valid_c, busy_c, mux_c;
  logic [2:0] sel_c;
  logic [7:0] in_c, data_c;
  assign mux_c = in_c[sel_c];

  int n_cmp = 0;
  int n_bad = 0;

  mux_scan_sequencer #(.SETTLE(1), .CONTINUOUS(1'b0)) dut (
    .clk(clk), .rst(rst), .start(start_a),
`ifdef MUX_SCAN_MASK_EN
    .ch_mask(mask_all),
`endif
    .mux_out(mux_a), .sel(sel_a), .snap_data(data_a),
    .snap_valid(valid_a), .snap_ready(ready_a), .busy(busy_a)
  );

  mux_scan_sequencer #(.SETTLE(1), .CONTINUOUS(1'b1)) dutc (
    .clk(clk), .rst(rst), .start(start_c),
`ifdef MUX_SCAN_MASK_EN
    .ch_mask(mask_all),
`endif
    .mux_out(mux_c), .sel(sel_c), .snap_data(data_c),
    .snap_valid(valid_c), .snap_ready(ready_c), .busy(busy_c)
  );

`ifdef MUX_SCAN_MASK_EN
  logic       start_m, ready_m, valid_m, busy_m, mux_m;
  logic [2:0] sel_m;
  logic [7:0] in_m, data_m, mask_m;
  assign mux_m = in_m[sel_m];

  mux_scan_sequencer #(.SETTLE(0), .CONTINUOUS(1'b0)) dutm (
    .clk(clk), .rst(rst), .start(start_m), .ch_mask(mask_m),
    .mux_out(mux_m), .sel(sel_m), .snap_data(data_m),
    .snap_valid(valid_m), .snap_ready(ready_m), .busy(busy_m)
  );
`endif

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1;
    start_a = 1'b0; ready_a = 1'b0; in_a = 8'h00;
    start_c = 1'b0; ready_c = 1'b1; in_c = 8'h3C;
`ifdef MUX_SCAN_MASK_EN
    start_m = 1'b0; ready_m = 1'b0; in_m = 8'hFF; mask_m = 8'h00;
`endif
    tick(2);
    rst = 1'b0;

    // reset state
    check("rst_sel",   8'(sel_a),   8'h00);
    check("rst_data",  data_a,      8'h00);
    check("rst_valid", 8'(valid_a), 8'h00);
    check("rst_busy",  8'(busy_a),  8'h00);

    // single scan of 8'hA5, two cycles per channel
    in_a = 8'hA5;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("scan_busy", 8'(busy_a), 8'h01);
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < 2; j++) begin
        check($sformatf("sel_ch%0d_c%0d", k, j), 8'(sel_a), 8'(k));
        check("valid_low_in_scan", 8'(valid_a), 8'h00);
        tick();
      end
    end
    check("valid_at_16", 8'(valid_a), 8'h01);
    check("data_a5",     data_a,      8'hA5);

    // consumer stalls five cycles
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("stall_valid_%0d", i), 8'(valid_a), 8'h01);
      check($sformatf("stall_data_%0d", i),  data_a,      8'hA5);
    end
    ready_a = 1'b1;
    tick();
    ready_a = 1'b0;
    check("hs_valid_drop", 8'(valid_a), 8'h00);
    check("hs_busy_idle",  8'(busy_a),  8'h00);
    check("idle_data_kept", data_a,     8'hA5);

    // start mid-scan is ignored; reset at channel 4 discards the scan
    in_a = 8'h5A;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick(3);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("midscan_sel2", 8'(sel_a), 8'h02);
    tick(4);
    check("at_ch4", 8'(sel_a), 8'h04);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_sel",   8'(sel_a),   8'h00);
    check("mrst_data",  data_a,      8'h00);
    check("mrst_valid", 8'(valid_a), 8'h00);
    check("mrst_busy",  8'(busy_a),  8'h00);
    tick(3);
    check("no_queued_start", 8'(busy_a), 8'h00);

    // normal scan after reset, ready held high before valid
    in_a = 8'h96;
    ready_a = 1'b1;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick(15);
    check("early_ready_valid", 8'(valid_a), 8'h00);
    tick();
    check("post_rst_valid", 8'(valid_a), 8'h01);
    check("post_rst_data",  data_a,      8'h96);
    tick();
    check("post_rst_hs_valid", 8'(valid_a), 8'h00);
    check("post_rst_hs_busy",  8'(busy_a),  8'h00);
    ready_a = 1'b0;

    // continuous: back-to-back scans with ready tied high
    start_c = 1'b1;
    tick();
    start_c = 1'b0;
    tick(15);
    check("c1_valid_early", 8'(valid_c), 8'h00);
    tick();
    check("c1_valid", 8'(valid_c), 8'h01);
    check("c1_data",  data_c,      8'h3C);
    in_c = 8'hC3;
    tick();
    check("c2_restart_valid", 8'(valid_c), 8'h00);
    check("c2_restart_busy",  8'(busy_c),  8'h01);
    check("c2_restart_sel",   8'(sel_c),   8'h00);
    tick(15);
    check("c2_valid_early", 8'(valid_c), 8'h00);
    tick();
    check("c2_valid", 8'(valid_c), 8'h01);
    check("c2_data",  data_c,      8'hC3);
    ready_c = 1'b0;

`ifdef MUX_SCAN_MASK_EN
    // masked scan, SETTLE = 0; mask change mid-scan must not matter
    mask_m = 8'b1000_0101;
    start_m = 1'b1;
    tick();
    start_m = 1'b0;
    mask_m = 8'hFF;
    check("m_sel0", 8'(sel_m), 8'h00);
    tick();
    check("m_sel2", 8'(sel_m), 8'h02);
    tick();
    check("m_sel7",   8'(sel_m),   8'h07);
    check("m_vlow",   8'(valid_m), 8'h00);
    tick();
    check("m_valid",  8'(valid_m), 8'h01);
    check("m_data85", data_m,      8'h85);
    ready_m = 1'b1;
    tick();
    ready_m = 1'b0;
    check("m_hs_busy", 8'(busy_m), 8'h00);

    // empty mask goes straight to HOLD
    mask_m = 8'h00;
    start_m = 1'b1;
    tick();
    start_m = 1'b0;
    check("m0_valid", 8'(valid_m), 8'h01);
    check("m0_data",  data_m,      8'h00);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
